// File: rtl/mst_cmd_arb_pkg.sv
// Shared types and defaults for the multi-channel command arbiter in front of a single master.
// The controller states and the registered command record live here.
package mst_cmd_arb_pkg;

  localparam int unsigned NchDefault = 4;
  localparam int unsigned CwDefault  = 3;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitLow  = 2'd2,
    StWaitDone = 2'd3
  } state_e;

  typedef struct packed {
    logic        wr;
    logic        burst;
    logic [2:0]  size;
    logic [9:0]  len;
    logic [31:0] addr;
  } cmd_t;

  localparam cmd_t CmdZero = '0;

endpackage

// File: rtl/mst_cmd_arb_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting one past the last
// winner and wrapping, returning the first requester found.
module rr_pick
  import mst_cmd_arb_pkg::*;
#(
  parameter int unsigned NCH = NchDefault,
  parameter int unsigned CW  = CwDefault
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last,
  output logic [CW-1:0]  win,
  output logic           vld
);

  always_comb begin
    win = '0;
    vld = 1'b0;
    // Offsets 1..NCH visit every channel once, ending on last itself.
    for (int k = 1; k <= int'(NCH); k++) begin
      for (int j = 0; j < int'(NCH); j++) begin
        if (!vld && req[j] && (j == ((int'(last) + k) % int'(NCH)))) begin
          win = CW'(j);
          vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mst_cmd_arb.sv
// Arbitrates NCH command channels onto one master port: grants round-robin, issues one Start
// per accepted command and routes the master handshake back to the owning channel.
module mst_cmd_arb
  import mst_cmd_arb_pkg::*;
#(
  parameter int unsigned NCH = NchDefault,
  parameter int unsigned CW  = CwDefault
) (
  input  logic              CLK,
  input  logic              RST_N,
  // channel side
  input  logic [NCH-1:0]    ChReq,
  input  logic [NCH-1:0]    ChWR,
  input  logic [NCH-1:0]    ChBurst,
  input  logic [NCH*32-1:0] ChAddr,
  input  logic [NCH*10-1:0] ChLen,
  input  logic [NCH*3-1:0]  ChSize,
  input  logic [NCH*32-1:0] ChDin,
  output logic [NCH-1:0]    ChAck,
  output logic [NCH-1:0]    ChDone,
  output logic [NCH-1:0]    ChErr,
  output logic [NCH-1:0]    ChReadEn,
  output logic [NCH-1:0]    ChDoutVld,
  output logic [31:0]       ChDout,
  // master side
  output logic              Start,
  output logic [2:0]        WRSize,
  output logic              WR,
  output logic [31:0]       WRAddr,
  output logic [9:0]        WRLen,
  output logic              WRBurst,
  output logic [31:0]       Din,
  input  logic              ReadEn,
  input  logic              DoutVld,
  input  logic [31:0]       Dout,
  input  logic              Done,
  // ownership
  output logic [CW-1:0]     Owner,
  output logic              OwnVld
);

  state_e          state_q, state_d;
  logic [CW-1:0]   last_q, last_d;
  logic [CW-1:0]   owner_q, owner_d;
  logic            own_vld_q, own_vld_d;
  cmd_t            cmd_q, cmd_d;

  logic [CW-1:0]   pick_win;
  logic            pick_vld;
  logic [NCH-1:0]  win_oh;
  logic [NCH-1:0]  owner_oh;
  cmd_t            win_cmd;
  logic [31:0]     din_mux;
  logic [NCH-1:0]  ack;
  logic [NCH-1:0]  err;
  logic [NCH-1:0]  done_v;
  cmd_t            cmd_out;

  rr_pick #(
    .NCH (NCH),
    .CW  (CW)
  ) u_rr_pick (
    .req  (ChReq),
    .last (last_q),
    .win  (pick_win),
    .vld  (pick_vld)
  );

  // Per-channel field selection for the candidate winner and the current owner.
  always_comb begin
    win_cmd  = CmdZero;
    win_oh   = '0;
    owner_oh = '0;
    din_mux  = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (CW'(i) == pick_win) begin
        win_oh[i]     = 1'b1;
        win_cmd.wr    = ChWR[i];
        win_cmd.burst = ChBurst[i];
        win_cmd.size  = ChSize[i*3 +: 3];
        win_cmd.len   = ChLen[i*10 +: 10];
        win_cmd.addr  = ChAddr[i*32 +: 32];
      end
      if (CW'(i) == owner_q) begin
        owner_oh[i] = 1'b1;
        din_mux     = ChDin[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    own_vld_d = own_vld_q;
    cmd_d     = cmd_q;
    ack       = '0;
    err       = '0;
    done_v    = '0;
    case (state_q)
      StIdle: begin
        // Grant pulses are Mealy outputs; RST_N gating keeps them quiet while reset is held.
        if (RST_N && Done && pick_vld) begin
          if (win_cmd.len == '0) begin
            err    = win_oh;
            done_v = win_oh;
            last_d = pick_win;
          end else begin
            ack       = win_oh;
            cmd_d     = win_cmd;
            owner_d   = pick_win;
            own_vld_d = 1'b1;
            state_d   = StIssue;
          end
        end
      end
      StIssue: state_d = StWaitLow;
      StWaitLow: begin
        if (!Done) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (Done) begin
          done_v    = owner_oh;
          last_d    = owner_q;
          own_vld_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      last_q    <= CW'(NCH - 1);
      owner_q   <= '0;
      own_vld_q <= 1'b0;
      cmd_q     <= CmdZero;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      own_vld_q <= own_vld_d;
      cmd_q     <= cmd_d;
    end
  end

  assign cmd_out = (state_q != StIdle) ? cmd_q : CmdZero;

  assign Start     = (state_q == StIssue);
  assign WR        = cmd_out.wr;
  assign WRBurst   = cmd_out.burst;
  assign WRSize    = cmd_out.size;
  assign WRLen     = cmd_out.len;
  assign WRAddr    = cmd_out.addr;
  assign Din       = own_vld_q ? din_mux : 32'h0;

  assign ChAck     = ack;
  assign ChErr     = err;
  assign ChDone    = done_v;
  assign ChReadEn  = (own_vld_q && ReadEn) ? owner_oh : '0;
  assign ChDoutVld = (own_vld_q && DoutVld) ? owner_oh : '0;
  assign ChDout    = Dout;

  assign Owner     = owner_q;
  assign OwnVld    = own_vld_q;

endmodule

// File: tb/tb_mst_cmd_arb.sv
// Bench for mst_cmd_arb: transaction-level reference model checked every cycle, a simple master
// responder, and directed scenarios with literal expectations.
module tb_mst_cmd_arb;

  localparam int NCH = 4;
  localparam int CW  = 3;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [NCH-1:0]    ChReq, ChWR, ChBurst;
  logic [NCH*32-1:0] ChAddr, ChDin;
  logic [NCH*10-1:0] ChLen;
  logic [NCH*3-1:0]  ChSize;
  logic [NCH-1:0]    ChAck, ChDone, ChErr, ChReadEn, ChDoutVld;
  logic [31:0]       ChDout;
  logic              Start, WR, WRBurst;
  logic [2:0]        WRSize;
  logic [31:0]       WRAddr, Din;
  logic [9:0]        WRLen;
  logic              ReadEn, DoutVld, Done;
  logic [31:0]       Dout;
  logic [CW-1:0]     Owner;
  logic              OwnVld;

  mst_cmd_arb #(.NCH(NCH), .CW(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ChReq(ChReq), .ChWR(ChWR), .ChBurst(ChBurst), .ChAddr(ChAddr), .ChLen(ChLen),
    .ChSize(ChSize), .ChDin(ChDin), .ChAck(ChAck), .ChDone(ChDone), .ChErr(ChErr),
    .ChReadEn(ChReadEn), .ChDoutVld(ChDoutVld), .ChDout(ChDout),
    .Start(Start), .WRSize(WRSize), .WR(WR), .WRAddr(WRAddr), .WRLen(WRLen),
    .WRBurst(WRBurst), .Din(Din), .ReadEn(ReadEn), .DoutVld(DoutVld), .Dout(Dout),
    .Done(Done), .Owner(Owner), .OwnVld(OwnVld)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 start, 2 awaiting Done low, 3 awaiting Done high.
  int          m_phase = 0, m_owner = 0, m_last = NCH - 1;
  bit          m_busy = 0;
  logic [46:0] m_cmd = '0;

  function automatic int rr(input logic [NCH-1:0] req, input int last);
    for (int k = 1; k <= NCH; k++) begin
      if (req[(last + k) % NCH]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  // Event logs for the directed checks.
  int          grant_q[$], err_q[$], done_q[$];
  logic [31:0] start_addr_q[$];
  int          start_cnt = 0, err_done_cnt = 0;
  int          re_cnt[NCH], dv_cnt[NCH];
  logic [31:0] dout_at_vld = '0;

  logic [NCH-1:0] e_ack, e_err, e_done, e_re, e_dv;
  logic [46:0]    e_wr;
  logic [31:0]    e_din;
  logic           e_start, e_vld;
  logic [CW-1:0]  e_owner;
  int             w;

  initial for (int i = 0; i < NCH; i++) begin re_cnt[i] = 0; dv_cnt[i] = 0; end

  always @(negedge CLK) begin
    if (!RST_N) begin
      m_phase = 0; m_busy = 0; m_owner = 0; m_last = NCH - 1;
      chk("rst_pulses", {ChAck, ChErr, ChDone}, '0);
      chk("rst_start", Start, 0);
      chk("rst_own", {OwnVld, Owner}, '0);
      chk("rst_wr", {WR, WRBurst, WRSize, WRLen, WRAddr}, '0);
    end else begin
      e_start = (m_phase == 1);
      e_wr    = (m_phase != 0) ? m_cmd : '0;
      e_vld   = m_busy;
      e_owner = CW'(m_owner);
      e_din   = m_busy ? ChDin[m_owner*32 +: 32] : 32'h0;
      e_re = '0; e_dv = '0; e_ack = '0; e_err = '0; e_done = '0;
      if (m_busy) begin e_re[m_owner] = ReadEn; e_dv[m_owner] = DoutVld; end
      case (m_phase)
        0: if (Done && ChReq != 0) begin
          w = rr(ChReq, m_last);
          if (ChLen[w*10 +: 10] == 0) begin
            e_err[w] = 1; e_done[w] = 1; m_last = w;
          end else begin
            e_ack[w] = 1; m_owner = w; m_busy = 1; m_phase = 1;
            m_cmd = {ChWR[w], ChBurst[w], ChSize[w*3 +: 3], ChLen[w*10 +: 10], ChAddr[w*32 +: 32]};
          end
        end
        1: m_phase = 2;
        2: if (!Done) m_phase = 3;
        default: if (Done) begin
          e_done[m_owner] = 1; m_last = m_owner; m_busy = 0; m_phase = 0;
        end
      endcase
      chk("ack", ChAck, e_ack);
      chk("err", ChErr, e_err);
      chk("done", ChDone, e_done);
      chk("start", Start, e_start);
      chk("wr_fields", {WR, WRBurst, WRSize, WRLen, WRAddr}, e_wr);
      chk("ownvld", OwnVld, e_vld);
      chk("owner", Owner, e_owner);
      chk("din", Din, e_din);
      chk("ch_readen", ChReadEn, e_re);
      chk("ch_doutvld", ChDoutVld, e_dv);
      chk("ch_dout", ChDout, Dout);
      for (int i = 0; i < NCH; i++) begin
        if (ChAck[i]) grant_q.push_back(i);
        if (ChErr[i]) begin err_q.push_back(i); if (ChDone[i]) err_done_cnt++; end
        if (ChDone[i] && !ChErr[i]) done_q.push_back(i);
        if (ChReadEn[i]) re_cnt[i]++;
        if (ChDoutVld[i]) dv_cnt[i]++;
      end
      if (Start) begin start_cnt++; start_addr_q.push_back(WRAddr); end
      if (|ChDoutVld) dout_at_vld = ChDout;
    end
  end

  // Master responder: Done drops after Start, one read-data beat, then Done returns.
  initial begin
    Done = 1'b1; ReadEn = 1'b0; DoutVld = 1'b0; Dout = 32'h0;
    forever begin
      @(negedge CLK);
      if (Start) begin
        @(posedge CLK); #1 Done = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1 ReadEn = 1'b1; DoutVld = 1'b1; Dout = 32'hA5A5A5A5;
        @(posedge CLK); #1 ReadEn = 1'b0; DoutVld = 1'b0; Dout = 32'h0;
        @(posedge CLK); #1 Done = 1'b1;
      end
    end
  end

  task automatic set_cmd(input int ch, input bit wr, input logic [31:0] addr,
                         input logic [9:0] len);
    ChWR[ch] = wr; ChBurst[ch] = ch[0]; ChSize[ch*3 +: 3] = 3'd2;
    ChAddr[ch*32 +: 32] = addr; ChLen[ch*10 +: 10] = len;
  endtask

  task automatic wait_ack(input int ch);
    bit got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge CLK);
      got = ChAck[ch] | ChErr[ch];
    end
    chk("ack_timeout", got, 1);
    @(posedge CLK); #1 ChReq[ch] = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    bit got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge CLK); #1;
      got = (done_q.size() > d0);
    end
    chk("done_timeout", got, 1);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge CLK);
      got = !OwnVld && Done && !Start;
    end
    chk("idle_timeout", got, 1);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK); #1 RST_N = 1'b0;
    repeat (n) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  int g0, s0, a0, d0, e0, ed0, r0, v0, vo, ok;

  initial begin
    ChReq = '0; ChWR = '0; ChBurst = '0; ChAddr = '0; ChLen = '0; ChSize = '0; ChDin = '0;
    for (int i = 0; i < NCH; i++) begin
      set_cmd(i, i[0], 32'h1000 * (i + 1), 10'd4);
      ChDin[i*32 +: 32] = 32'hD000_0000 + i;
    end
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("reset_owner", Owner, 0);
    chk("reset_ownvld", OwnVld, 0);
    chk("reset_start", Start, 0);

    // Single write on channel 0.
    set_cmd(0, 1, 32'h100, 10'd4);
    g0 = grant_q.size(); s0 = start_cnt; a0 = start_addr_q.size(); d0 = done_q.size();
    r0 = re_cnt[0];
    @(posedge CLK); #1 ChReq = 4'b0001;
    wait_ack(0);
    wait_done(d0);
    wait_idle();
    chk("t1_ngrant", grant_q.size() - g0, 1);
    chk("t1_grant", grant_q[g0], 0);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_addr", start_addr_q[a0], 32'h100);
    chk("t1_readen0", re_cnt[0] - r0, 1);
    chk("t1_done_ch", done_q[d0], 0);

    // All four requesting continuously from reset.
    do_reset(2);
    g0 = grant_q.size();
    ChReq = 4'b1111;
    ok = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge CLK); #1;
      ok = (grant_q.size() >= g0 + 5);
    end
    chk("t2_timeout", ok, 1);
    @(posedge CLK); #1 ChReq = '0;
    wait_idle();
    chk("t2_ngrant", grant_q.size() - g0, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), grant_q[g0 + k], k % 4);
    ok = 1;
    for (int k = 1; k < 5; k++) if (grant_q[g0 + k] == grant_q[g0 + k - 1]) ok = 0;
    chk("t2_no_repeat", ok, 1);

    // Zero-length command on channel 2 alongside channel 3.
    set_cmd(2, 1, 32'h2200, 10'd0);
    g0 = grant_q.size(); s0 = start_cnt; e0 = err_q.size(); ed0 = err_done_cnt;
    d0 = done_q.size();
    ChReq = 4'b1100;
    wait_ack(2);
    wait_ack(3);
    wait_done(d0);
    wait_idle();
    chk("t3_nerr", err_q.size() - e0, 1);
    chk("t3_err_ch", err_q[e0], 2);
    chk("t3_err_done_same", err_done_cnt - ed0, 1);
    chk("t3_next_grant", grant_q[g0], 3);
    chk("t3_starts", start_cnt - s0, 1);

    // Read on channel 1: read data routed only to channel 1.
    set_cmd(2, 1, 32'h2200, 10'd4);
    set_cmd(1, 0, 32'h300, 10'd8);
    d0 = done_q.size(); v0 = dv_cnt[1];
    vo = dv_cnt[0] + dv_cnt[2] + dv_cnt[3];
    ChReq = 4'b0010;
    wait_ack(1);
    wait_done(d0);
    wait_idle();
    chk("t4_dv1", dv_cnt[1] - v0, 1);
    chk("t4_dv_others", dv_cnt[0] + dv_cnt[2] + dv_cnt[3] - vo, 0);
    chk("t4_dout", dout_at_vld, 32'hA5A5A5A5);
    chk("t4_done_ch", done_q[d0], 1);

    // Reset while waiting for Done: transfer abandoned, no completion.
    d0 = done_q.size();
    ChReq = 4'b1000;
    wait_ack(3);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge CLK); ok = Start; end
    chk("t5_start_seen", ok, 1);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK); #1;
    chk("t5_no_done", done_q.size() - d0, 0);
    chk("t5_ownvld", OwnVld, 0);
    chk("t5_start", Start, 0);
    wait_idle();
    g0 = grant_q.size();
    ChReq = 4'b0101;
    wait_ack(0);
    ChReq = '0;
    wait_idle();
    chk("t5_grant_after_reset", grant_q[g0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
